// File: rtl/regfile_banked.sv
// -----------------------------------------------------------------------------
// regfile_banked
//
// Purpose:
//   Register file for the risc8 core, between decode and ALU. It holds NREGS
//   registers of W bits in two byte banks: registers with an even index go in
//   the even bank and registers with an odd index go in the odd bank. Each
//   bank is kept as two identical copies, so read ports A and B are
//   independent. Every write updates both copies.
//
//   Read port A returns a register pair {R[a+1], R[a]}. a may be odd, so a
//   pair can start at any register. Read port B returns the single register
//   R[b]. Both reads have one cycle of latency.
//
//   Block RAM has no reset. After every reset a hardware sequence therefore
//   writes zero into every entry, and busy stays high while it runs.
//
// Configuration:
//   REGFILE_BYPASS_EN  defined   : write-first. A write and a read sampled on
//                                  the same edge return the new bytes, decided
//                                  per byte lane.
//                      undefined : read-first. A read on the same edge returns
//                                  the old RAM contents.
//
// Ports:
//   clk         clock; all state changes on posedge
//   reset       asynchronous, active-high reset
//   busy        high while the clear sequence runs
//   a           read port A index (pair read)
//   b           read port B index (single read)
//   Ra          {R[a+1], R[a]}; a lane whose index is out of range reads 0
//   Rb          R[b]
//   write       write strobe (ignored while busy)
//   write_word  1 = pair write, 0 = single write
//   d           write index (a pair write forces it even)
//   Rd          write data; a single write uses Rd[W-1:0]
//   misalign    one-cycle pulse after a pair write accepted with d odd
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------------
// CLEAR | zeroing bank entry clr_cnt each cycle; writes ignored, reads give 0
// READY | normal operation; left only through reset
//
module regfile_banked #(
  parameter int NREGS  = 32,
  parameter int W      = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  output logic [2*W-1:0]    Ra,
  output logic [W-1:0]      Rb,
  input  logic              write,
  input  logic              write_word,
  input  logic [ADDR_W-1:0] d,
  input  logic [2*W-1:0]    Rd,
  output logic              misalign
);

  localparam int HALF = NREGS / 2;
  // The entry index inside a bank drops the bank-select bit.
  localparam int BI_W = ADDR_W - 1;

  localparam logic [ADDR_W:0] NREGS_X = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);
  localparam logic [BI_W:0]   HALF_X  = (BI_W+1)'(HALF);
  localparam logic [BI_W-1:0] LAST_E  = BI_W'(HALF - 1);
  localparam logic [BI_W-1:0] ONE_E   = BI_W'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state;
  logic [BI_W-1:0] clr_cnt;

  // Bank storage, two copies of each bank.
  logic [W-1:0] even_a [HALF];
  logic [W-1:0] even_b [HALF];
  logic [W-1:0] odd_a  [HALF];
  logic [W-1:0] odd_b  [HALF];

  // Keeps an entry index inside the array. An index outside the array only
  // occurs together with an out-of-range register index, and that lane is
  // forced to 0 at the output anyway.
  function automatic logic [BI_W-1:0] clamp_entry(input logic [BI_W-1:0] e);
    return ({1'b0, e} < HALF_X) ? e : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Read address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0] a_x;
  logic [ADDR_W:0] a_x1;
  logic [ADDR_W:0] b_x;
  logic            a_lo_in;
  logic            a_hi_in;
  logic            b_in;
  logic [BI_W-1:0] ea_idx;
  logic [BI_W-1:0] oa_idx;
  logic [BI_W-1:0] b_idx;

  assign a_x  = {1'b0, a};
  assign a_x1 = a_x + ONE_X;
  assign b_x  = {1'b0, b};

  assign a_lo_in = (a_x  < NREGS_X);
  assign a_hi_in = (a_x1 < NREGS_X);
  assign b_in    = (b_x  < NREGS_X);

  // For an odd a, the upper byte of the pair is the next even register, so
  // the even-bank entry advances by one. The odd-bank entry is a>>1 either way.
  assign ea_idx = clamp_entry(a[0] ? a_x1[BI_W:1] : a[ADDR_W-1:1]);
  assign oa_idx = clamp_entry(a[ADDR_W-1:1]);
  assign b_idx  = clamp_entry(b[ADDR_W-1:1]);

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic            wr_acc;
  logic            single_ok;
  logic            pair_ok;
  logic            we_even;
  logic            we_odd;
  logic [BI_W-1:0] w_idx;
  logic [W-1:0]    wd_even;
  logic [W-1:0]    wd_odd;

  assign wr_acc    = (state == READY) && write;
  assign single_ok = ({1'b0, d} < NREGS_X);
  // NREGS is even, so if the even base of a pair is in range, so is base+1.
  assign pair_ok   = ({1'b0, d[ADDR_W-1:1], 1'b0} < NREGS_X);
  assign w_idx     = d[ADDR_W-1:1];

  assign we_even = wr_acc && (write_word ? pair_ok : (single_ok && !d[0]));
  assign we_odd  = wr_acc && (write_word ? pair_ok : (single_ok &&  d[0]));
  assign wd_even = Rd[W-1:0];
  assign wd_odd  = write_word ? Rd[2*W-1:W] : Rd[W-1:0];

  // ---------------------------------------------------------------------------
  // RAM: no reset on the arrays or their read registers. Reads are
  // read-first, so a read on the same edge as a write sees the old contents.
  // ---------------------------------------------------------------------------
  logic [W-1:0] ram_ea_q;
  logic [W-1:0] ram_oa_q;
  logic [W-1:0] ram_eb_q;
  logic [W-1:0] ram_ob_q;

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      even_a[clr_cnt] <= '0;
      even_b[clr_cnt] <= '0;
      odd_a[clr_cnt]  <= '0;
      odd_b[clr_cnt]  <= '0;
    end else begin
      if (we_even) begin
        even_a[w_idx] <= wd_even;
        even_b[w_idx] <= wd_even;
      end
      if (we_odd) begin
        odd_a[w_idx] <= wd_odd;
        odd_b[w_idx] <= wd_odd;
      end
    end
    ram_ea_q <= even_a[ea_idx];
    ram_oa_q <= odd_a[oa_idx];
    ram_eb_q <= even_b[b_idx];
    ram_ob_q <= odd_b[b_idx];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered read qualifiers
  // ---------------------------------------------------------------------------
  logic a_lo_ok;
  logic a_hi_ok;
  logic b_ok;
  logic a_odd_q;
  logic b_odd_q;

`ifdef REGFILE_BYPASS_EN
  logic            byp_even_en;
  logic            byp_odd_en;
  logic [BI_W-1:0] byp_idx;
  logic [W-1:0]    byp_even_d;
  logic [W-1:0]    byp_odd_d;
  logic [BI_W-1:0] ea_idx_q;
  logic [BI_W-1:0] oa_idx_q;
  logic [BI_W-1:0] b_idx_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      busy     <= 1'b1;
      misalign <= 1'b0;
      a_lo_ok  <= 1'b0;
      a_hi_ok  <= 1'b0;
      b_ok     <= 1'b0;
      a_odd_q  <= 1'b0;
      b_odd_q  <= 1'b0;
`ifdef REGFILE_BYPASS_EN
      byp_even_en <= 1'b0;
      byp_odd_en  <= 1'b0;
      byp_idx     <= '0;
      byp_even_d  <= '0;
      byp_odd_d   <= '0;
      ea_idx_q    <= '0;
      oa_idx_q    <= '0;
      b_idx_q     <= '0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_E) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ONE_E;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase

      misalign <= wr_acc && write_word && pair_ok && d[0];

      // Reads sampled while clearing return 0. RAM is not yet valid then.
      a_lo_ok <= (state == READY) && a_lo_in;
      a_hi_ok <= (state == READY) && a_hi_in;
      b_ok    <= (state == READY) && b_in;
      a_odd_q <= a[0];
      b_odd_q <= b[0];

`ifdef REGFILE_BYPASS_EN
      byp_even_en <= we_even;
      byp_odd_en  <= we_odd;
      byp_idx     <= w_idx;
      byp_even_d  <= wd_even;
      byp_odd_d   <= wd_odd;
      ea_idx_q    <= ea_idx;
      oa_idx_q    <= oa_idx;
      b_idx_q     <= b_idx;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank read values, then lane steering
  // ---------------------------------------------------------------------------
  logic [W-1:0] ea_v;
  logic [W-1:0] oa_v;
  logic [W-1:0] eb_v;
  logic [W-1:0] ob_v;

`ifdef REGFILE_BYPASS_EN
  // Compare the registered write entry with the registered read entry of
  // each bank. Each lane is then taken from the write data or from RAM.
  assign ea_v = (byp_even_en && (byp_idx == ea_idx_q)) ? byp_even_d : ram_ea_q;
  assign oa_v = (byp_odd_en  && (byp_idx == oa_idx_q)) ? byp_odd_d  : ram_oa_q;
  assign eb_v = (byp_even_en && (byp_idx == b_idx_q))  ? byp_even_d : ram_eb_q;
  assign ob_v = (byp_odd_en  && (byp_idx == b_idx_q))  ? byp_odd_d  : ram_ob_q;
`else
  assign ea_v = ram_ea_q;
  assign oa_v = ram_oa_q;
  assign eb_v = ram_eb_q;
  assign ob_v = ram_ob_q;
`endif

  // For an odd a, the banks swap lanes: the odd bank supplies the low byte.
  assign Ra[W-1:0]   = a_lo_ok ? (a_odd_q ? oa_v : ea_v) : '0;
  assign Ra[2*W-1:W] = a_hi_ok ? (a_odd_q ? ea_v : oa_v) : '0;
  assign Rb          = b_ok    ? (b_odd_q ? ob_v : eb_v) : '0;

endmodule
